gmii_rx_frame_parser: RTL and testbench

- Consumes the registered GMII RX byte stream (RXD/DV/ER) produced by the RGMII-to-GMII receive stage.
- Strips the preamble and SFD, delays payload by 5 bytes so the FCS is removed, and checks CRC-32, length and GMII errors.
- Emits a byte stream with sof/eof plus a one-cycle status beat per frame to the downstream MAC/UDP receive logic.
- Sits entirely in the RX clock domain.

---
 rtl/gbe_rx_pkg.sv | 17 +
 rtl/crc32_d8.sv | 22 ++
 rtl/gmii_rx_frame_parser.sv | 128 ++++++++++++
 tb/tb_gmii_rx_frame_parser.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gbe_rx_pkg.sv
// Shared GMII receive constants and the frame parser state encoding.
package gbe_rx_pkg;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_FRAME    = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC-32 step for one byte, data taken LSB first.
module crc32_d8
    import gbe_rx_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // MSB-first register fed with the byte LSB first: over data+FCS this lands on CRC_RESIDUE.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[31] ^ data[i]) begin
                crc_next = {crc_next[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_next = {crc_next[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD and FCS, checks CRC, length and ER.
// rx_valid_o qualifies rx_data_o/rx_sof_o/rx_eof_o; there is no backpressure, every beat must be taken.
module gmii_rx_frame_parser
    import gbe_rx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        GMII_RX_CLK_i,
    input  logic        reset_n,
    input  logic [7:0]  GMII_RX_RXD_i,
    input  logic        GMII_RX_DV_i,
    input  logic        GMII_RX_ER_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_sof_o,
    output logic        rx_eof_o,
    output logic        rx_stat_valid_o,
    output logic        rx_stat_good_o,
    output logic        rx_stat_crc_err_o,
    output logic        rx_stat_len_err_o,
    output logic        rx_stat_gmii_err_o,
    output logic [10:0] rx_stat_len_o
);

    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;

    rx_state_t      state;
    logic           dv_d;
    logic [10:0]    len;
    logic [31:0]    crc;
    logic [31:0]    crc_next;
    logic           gmii_err;
    logic [4:0][7:0] dline;
    logic           start;
    logic           end_crc_err;
    logic           end_len_err;

    crc32_d8 u_crc32_d8 (
        .crc      (crc),
        .data     (GMII_RX_RXD_i),
        .crc_next (crc_next)
    );

    assign start       = GMII_RX_DV_i && !dv_d;
    assign end_crc_err = (crc != CRC_RESIDUE) || (len < 11'd5);
    assign end_len_err = (len < MIN_LEN) || (len > MAX_LEN);

    always_ff @(posedge GMII_RX_CLK_i or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            dv_d               <= 1'b1;
            len                <= '0;
            crc                <= CRC_INIT;
            gmii_err           <= 1'b0;
            dline              <= '0;
            rx_data_o          <= '0;
            rx_valid_o         <= 1'b0;
            rx_sof_o           <= 1'b0;
            rx_eof_o           <= 1'b0;
            rx_stat_valid_o    <= 1'b0;
            rx_stat_good_o     <= 1'b0;
            rx_stat_crc_err_o  <= 1'b0;
            rx_stat_len_err_o  <= 1'b0;
            rx_stat_gmii_err_o <= 1'b0;
            rx_stat_len_o      <= '0;
        end else begin
            dv_d            <= GMII_RX_DV_i;
            rx_valid_o      <= 1'b0;
            rx_sof_o        <= 1'b0;
            rx_eof_o        <= 1'b0;
            rx_stat_valid_o <= 1'b0;
            case (state)
                ST_IDLE, ST_PREAMBLE: begin
                    if ((state == ST_IDLE && start) || (state == ST_PREAMBLE && GMII_RX_DV_i)) begin
                        if (GMII_RX_RXD_i == PREAMBLE) begin
                            state <= ST_PREAMBLE;
                        end else if (GMII_RX_RXD_i == SFD) begin
                            state    <= ST_FRAME;
                            crc      <= CRC_INIT;
                            len      <= '0;
                            gmii_err <= 1'b0;
                        end else begin
                            state <= ST_DROP;
                        end
                    end else if (state == ST_PREAMBLE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FRAME: begin
                    if (GMII_RX_DV_i) begin
                        crc   <= crc_next;
                        dline <= {dline[3:0], GMII_RX_RXD_i};
                        if (len != LEN_SAT) len <= len + 11'd1;
                        if (GMII_RX_ER_i) gmii_err <= 1'b1;
                        // Delay line full: the byte falling out is known not to be FCS.
                        if (len >= 11'd5) begin
                            rx_valid_o <= 1'b1;
                            rx_data_o  <= dline[4];
                            rx_sof_o   <= (len == 11'd5);
                        end
                    end else begin
                        state <= ST_IDLE;
                        if (len >= 11'd5) begin
                            rx_valid_o <= 1'b1;
                            rx_data_o  <= dline[4];
                            rx_sof_o   <= (len == 11'd5);
                            rx_eof_o   <= 1'b1;
                        end
                        rx_stat_valid_o    <= 1'b1;
                        rx_stat_crc_err_o  <= end_crc_err;
                        rx_stat_len_err_o  <= end_len_err;
                        rx_stat_gmii_err_o <= gmii_err;
                        rx_stat_good_o     <= !(end_crc_err || end_len_err || gmii_err);
                        rx_stat_len_o      <= len;
                    end
                end
                ST_DROP: begin
                    if (!GMII_RX_DV_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Directed bench for gmii_rx_frame_parser with beat and status scoreboards.
module tb_gmii_rx_frame_parser;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_sof_o, rx_eof_o;
    logic        rx_stat_valid_o, rx_stat_good_o, rx_stat_crc_err_o;
    logic        rx_stat_len_err_o, rx_stat_gmii_err_o;
    logic [10:0] rx_stat_len_o;

    gmii_rx_frame_parser #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518)) dut (
        .GMII_RX_CLK_i      (clk),
        .reset_n            (reset_n),
        .GMII_RX_RXD_i      (rxd),
        .GMII_RX_DV_i       (dv),
        .GMII_RX_ER_i       (er),
        .rx_data_o          (rx_data_o),
        .rx_valid_o         (rx_valid_o),
        .rx_sof_o           (rx_sof_o),
        .rx_eof_o           (rx_eof_o),
        .rx_stat_valid_o    (rx_stat_valid_o),
        .rx_stat_good_o     (rx_stat_good_o),
        .rx_stat_crc_err_o  (rx_stat_crc_err_o),
        .rx_stat_len_err_o  (rx_stat_len_err_o),
        .rx_stat_gmii_err_o (rx_stat_gmii_err_o),
        .rx_stat_len_o      (rx_stat_len_o)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // scoreboard: beat = {sof, eof, data}, status = {good, crc, len, gmii, len[10:0]}
    logic [9:0]  exp_q[$];
    int          exp_cyc_q[$];
    logic [14:0] stat_q[$];
    int          stat_cyc_q[$];
    logic [7:0]  fb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // reference CRC: reflected LFSR, final inversion, over fb[0..cnt-1]
    function automatic logic [31:0] fcs_of(input int cnt);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < cnt; k++) begin
            c = c ^ {24'h0, fb[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_payload(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'(i));
    endtask

    task automatic append_fcs();
        logic [31:0] f;
        f = fcs_of(fb.size());
        fb.push_back(f[7:0]);
        fb.push_back(f[15:8]);
        fb.push_back(f[23:16]);
        fb.push_back(f[31:24]);
    endtask

    task automatic drive(input logic dv_v, input logic er_v, input logic [7:0] d);
        @(negedge clk);
        dv  = dv_v;
        er  = er_v;
        rxd = d;
    endtask

    task automatic send_frame(input int er_idx);
        int n;
        logic crc_ok, crc_e, len_e, gm_e;
        logic [31:0] f;
        logic [10:0] l;
        n = fb.size();
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int j = 0; j < n; j++) begin
            drive(1'b1, j == er_idx, fb[j]);
            if (j >= 5) begin
                exp_q.push_back({j == 5, 1'b0, fb[j-5]});
                exp_cyc_q.push_back(cyc + 1);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        if (n >= 5) begin
            exp_q.push_back({n == 5, 1'b1, fb[n-5]});
            exp_cyc_q.push_back(cyc + 1);
        end
        crc_ok = 1'b0;
        if (n >= 4) begin
            f = fcs_of(n - 4);
            crc_ok = (f == {fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
        end
        crc_e = (n < 5) || !crc_ok;
        len_e = (n < 64) || (n > 1518);
        gm_e  = (er_idx >= 0) && (er_idx < n);
        l     = (n > 2047) ? 11'd2047 : 11'(n);
        stat_q.push_back({!(crc_e || len_e || gm_e), crc_e, len_e, gm_e, l});
        stat_cyc_q.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    // monitor: compare beats and status strobes against the queues
    always @(negedge clk) begin
        logic [9:0]  eb;
        logic [14:0] es;
        int          ec;
        if (reset_n) begin
            if (rx_valid_o) begin
                chk("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    eb = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    chk("beat_data", rx_data_o, eb[7:0]);
                    chk("beat_sof", rx_sof_o, eb[9]);
                    chk("beat_eof", rx_eof_o, eb[8]);
                    chk("beat_cycle", cyc, ec);
                end
            end
            if (rx_stat_valid_o) begin
                chk("stat_expected", stat_q.size() != 0, 1'b1);
                if (stat_q.size() != 0) begin
                    es = stat_q.pop_front();
                    ec = stat_cyc_q.pop_front();
                    chk("stat_good", rx_stat_good_o, es[14]);
                    chk("stat_crc_err", rx_stat_crc_err_o, es[13]);
                    chk("stat_len_err", rx_stat_len_err_o, es[12]);
                    chk("stat_gmii_err", rx_stat_gmii_err_o, es[11]);
                    chk("stat_len", rx_stat_len_o, es[10:0]);
                    chk("stat_cycle", cyc, ec);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        dv      = 1'b0;
        er      = 1'b0;
        rxd     = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_valid", rx_valid_o, 1'b0);
        chk("reset_data", rx_data_o, 8'h00);
        chk("reset_stat_valid", rx_stat_valid_o, 1'b0);
        chk("reset_stat_len", rx_stat_len_o, 11'd0);
        chk("reset_stat_good", rx_stat_good_o, 1'b0);
        reset_n = 1'b1;
        idle(3);

        // 1: minimum good frame
        make_payload(60); append_fcs(); send_frame(-1); idle(3);
        // 2: corrupted payload byte
        make_payload(60); append_fcs(); fb[10] = 8'hFF; send_frame(-1); idle(3);
        // 3: runt, no beats
        make_payload(2); send_frame(-1); idle(3);
        // exactly 5 bytes: sof and eof on one beat
        make_payload(5); send_frame(-1); idle(3);
        // 4: oversize frame with valid FCS
        make_payload(1596); append_fcs(); send_frame(-1); idle(3);
        // 5: ER on byte 20, then back-to-back good frame after one idle
        make_payload(60); append_fcs(); send_frame(20);
        make_payload(60); append_fcs(); send_frame(-1); idle(3);

        // 6: reset asserted mid-frame, released while DV still high
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(i));
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 8'h55);
        chk("midreset_valid", rx_valid_o, 1'b0);
        chk("midreset_stat_valid", rx_stat_valid_o, 1'b0);
        chk("midreset_stat_len", rx_stat_len_o, 11'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i + 40));
        idle(2);
        make_payload(60); append_fcs(); send_frame(-1); idle(3);

        // preamble broken by 0xAA: dropped until DV low
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hAA);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i));
        idle(1);
        make_payload(60); append_fcs(); send_frame(-1);
        idle(10);

        chk("beats_drained", exp_q.size(), 0);
        chk("stats_drained", stat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
